// File: rtl/next_pc_gen_pkg.sv
// Shared constants for the next-PC generator.
// The misaligned-target trap path is enabled by defining NPC_MISALIGN_CHECK_EN.
package next_pc_gen_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int XLEN = 32;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC_DEF  = 32'h0000_0100;

  // A target is misaligned when either of its two low bits is set.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_gen_npc_sel.sv
// Combinational next-PC select: taken target (op1 + op2) or fall-through (op2).
// With NPC_MISALIGN_CHECK_EN defined it also flags misaligned taken targets.
module next_pc_gen_npc_sel
  import next_pc_gen_pkg::*;
#(
  parameter int XLEN = next_pc_gen_pkg::XLEN
) (
  input  logic [XLEN-1:0] npc_op1,
  input  logic [XLEN-1:0] npc_op2,
  input  logic            br_taken,
`ifdef NPC_MISALIGN_CHECK_EN
  output logic            misaligned,
`endif
  output logic [XLEN-1:0] npc
);

  logic [XLEN-1:0] target;

  // Modulo-2^XLEN add; the carry-out is intentionally dropped.
  assign target = npc_op1 + npc_op2;
  assign npc    = (br_taken == ENABLE) ? target : npc_op2;

`ifdef NPC_MISALIGN_CHECK_EN
  // Only taken targets are checked; fall-through is never flagged.
  assign misaligned = (br_taken == ENABLE) && is_misaligned(npc[1:0]);
`endif

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC generator: npc select plus the architectural PC register.
// Defining NPC_MISALIGN_CHECK_EN redirects misaligned taken targets to TRAP_PC.
module next_pc_gen
  import next_pc_gen_pkg::*;
#(
  parameter int              XLEN     = next_pc_gen_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
`ifdef NPC_MISALIGN_CHECK_EN
  ,
  parameter logic [XLEN-1:0] TRAP_PC  = TRAP_PC_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] npc_op1,
  input  logic [XLEN-1:0] npc_op2,
  input  logic            br_taken,
  input  logic            stall,
  output logic [XLEN-1:0] npc,
`ifdef NPC_MISALIGN_CHECK_EN
  output logic            misaligned,
`endif
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;

`ifdef NPC_MISALIGN_CHECK_EN
  logic mis;

  next_pc_gen_npc_sel #(.XLEN(XLEN)) u_npc_sel (
    .npc_op1    (npc_op1),
    .npc_op2    (npc_op2),
    .br_taken   (br_taken),
    .misaligned (mis),
    .npc        (npc)
  );

  assign misaligned = mis;
  // npc still shows the raw target; only the register is redirected.
  assign pc_d = mis ? TRAP_PC : npc;
`else
  next_pc_gen_npc_sel #(.XLEN(XLEN)) u_npc_sel (
    .npc_op1  (npc_op1),
    .npc_op2  (npc_op2),
    .br_taken (br_taken),
    .npc      (npc)
  );

  assign pc_d = npc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc <= RESET_PC;
    else if (!stall) pc <= pc_d;
  end

endmodule

// File: tb/tb_next_pc_gen.sv
// Randomized bench for next_pc_gen against an arithmetic reference model,
// plus directed literal checks; honours NPC_MISALIGN_CHECK_EN like the design.
module tb_next_pc_gen;
  import next_pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op1, op2;
  logic        taken, stall;
  logic [31:0] npc, pc;
`ifdef NPC_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc;
  bit chk_en = 1'b0;

  next_pc_gen dut (
    .clk        (clk),
    .rst        (rst),
    .npc_op1    (op1),
    .npc_op2    (op2),
    .br_taken   (taken),
    .stall      (stall),
    .npc        (npc),
`ifdef NPC_MISALIGN_CHECK_EN
    .misaligned (misaligned),
`endif
    .pc         (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_npc(input logic [31:0] a, input logic [31:0] b, input logic t);
    longint unsigned sum;
    sum = (longint'(a) + longint'(b)) % 64'h1_0000_0000;
    return t ? sum[31:0] : b;
  endfunction

  function automatic logic ref_mis(input logic [31:0] a, input logic [31:0] b, input logic t);
    logic [31:0] v;
    v = ref_npc(a, b, t);
    return t && ((v % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [31:0] a, input logic [31:0] b, input logic t);
`ifdef NPC_MISALIGN_CHECK_EN
    if (ref_mis(a, b, t)) return TRAP_PC_DEF;
`endif
    return ref_npc(a, b, t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model register: advances on every unstalled edge outside reset.
  always @(posedge clk) begin
    if (!rst && !stall) m_pc = ref_next_pc(op1, op2, taken);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("npc_model", npc, ref_npc(op1, op2, taken));
      check("pc_model", pc, m_pc);
`ifdef NPC_MISALIGN_CHECK_EN
      check("mis_model", {31'b0, misaligned}, {31'b0, ref_mis(op1, op2, taken)});
`endif
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic t, input logic s);
    op1 = a; op2 = b; taken = t; stall = s;
  endtask

  task automatic next_slot();
    @(negedge clk); #2;
  endtask

  task automatic assert_rst();
    rst = 1'b1; m_pc = RESET_PC_DEF;
  endtask

  initial begin
    assert_rst();
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    chk_en = 1'b1;
    #1;
    check("reset_pc", pc, 32'h0);

    // npc is combinational and reflects inputs even while in reset
    next_slot();
    drive(32'd10, 32'd14, 1'b1, 1'b1);
    #10 check("jump_npc", npc, 32'd24);
    check("reset_hold_pc", pc, 32'h0);
    drive(32'd10, 32'd14, 1'b0, 1'b1);
    #10 check("fallthru_npc", npc, 32'd14);
    drive(32'h8, 32'hFFFF_FFFC, 1'b1, 1'b1);
    #1 check("wrap_npc", npc, 32'h0000_0004);

    next_slot();
    rst = 1'b0;
    drive(32'd10, 32'd14, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("first_edge_pc", pc, 32'd24);

    next_slot();
    drive(32'd100, 32'd200, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("stall_hold_pc", pc, 32'd24);
    #2 assert_rst();
    #1 check("async_rst_stall_pc", pc, 32'h0);

    next_slot();
    rst = 1'b0;
    drive(32'd10, 32'd14, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("after_rst_pc", pc, 32'd24);
    next_slot();
    drive(32'd4, 32'd40, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("unstall_follow_pc", pc, 32'd40);

    next_slot();
    drive(32'd2, 32'd8, 1'b1, 1'b0);
    #1 check("mis_npc", npc, 32'd10);
`ifdef NPC_MISALIGN_CHECK_EN
    check("mis_flag", {31'b0, misaligned}, 32'd1);
    @(posedge clk); #1;
    check("mis_trap_pc", pc, 32'h0000_0100);
`else
    @(posedge clk); #1;
    check("unaligned_pc", pc, 32'd10);
`endif
    next_slot();
    drive(32'd2, 32'd8, 1'b0, 1'b0);
`ifdef NPC_MISALIGN_CHECK_EN
    #1 check("notaken_mis_flag", {31'b0, misaligned}, 32'd0);
`endif
    @(posedge clk); #1;
    check("notaken_pc", pc, 32'd8);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, b;
      next_slot();
      if ($urandom_range(0, 49) == 0) assert_rst();
      else rst = 1'b0;
      case ($urandom_range(0, 3))
        0: begin a = $urandom_range(0, 64); b = {$urandom_range(0, 1023), 2'b00}; end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = $urandom_range(0, 32); b = 32'hFFFF_FFE0 + $urandom_range(0, 31); end
        default: begin a = {$urandom, 2'b00}; b = {$urandom, 2'b00}; end
      endcase
      drive(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    next_slot();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
